// File: rtl/flag_unit_pkg.sv
// Shared CPU definitions used by the flag unit: opcodes, flag bit positions,
// branch condition encodings, flag update masks and the hazard FSM states.
package cpu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  localparam logic [2:0] COND_NEQ    = 3'b000;
  localparam logic [2:0] COND_EQ     = 3'b001;
  localparam logic [2:0] COND_GT     = 3'b010;
  localparam logic [2:0] COND_LT     = 3'b011;
  localparam logic [2:0] COND_GE     = 3'b100;
  localparam logic [2:0] COND_LE     = 3'b101;
  localparam logic [2:0] COND_OVFL   = 3'b110;
  localparam logic [2:0] COND_UNCOND = 3'b111;

  localparam logic [2:0] MASK_NONE = 3'b000;
  localparam logic [2:0] MASK_Z    = 3'b100;
  localparam logic [2:0] MASK_ZVN  = 3'b111;

  typedef enum logic {
    HZ_IDLE = 1'b0,
    HZ_WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/flag_unit_if.sv
// Branch-condition interface between the EX/ID pipeline (master) and the
// flag unit (slave).
//   master drives : ex_valid, ex_op, ex_result, ex_ovfl, stall, flush,
//                   id_is_branch, id_cond
//   slave drives  : flags {Z,V,N}, flag_hazard, flags_busy
interface flag_unit_if #(
  parameter int DW = 16
);
  logic          ex_valid;
  logic [3:0]    ex_op;
  logic [DW-1:0] ex_result;
  logic          ex_ovfl;
  logic          stall;
  logic          flush;
  logic          id_is_branch;
  logic [2:0]    id_cond;
  logic [2:0]    flags;
  logic          flag_hazard;
  logic          flags_busy;

  modport master (
    output ex_valid, ex_op, ex_result, ex_ovfl, stall, flush,
           id_is_branch, id_cond,
    input  flags, flag_hazard, flags_busy
  );

  modport slave (
    input  ex_valid, ex_op, ex_result, ex_ovfl, stall, flush,
           id_is_branch, id_cond,
    output flags, flag_hazard, flags_busy
  );
endinterface

// File: rtl/flag_unit_mask_dec.sv
// flag_mask_dec: maps an EX opcode to its {Z,V,N} flag update mask.
//   i_op   : EX-stage opcode
//   o_mask : bits set for flags the opcode writes
module flag_mask_dec
  import cpu_pkg::*;
(
  input  logic [3:0] i_op,
  output logic [2:0] o_mask
);

  always_comb begin
    o_mask = MASK_NONE;
    case (i_op)
      OP_ADD, OP_SUB:                 o_mask = MASK_ZVN;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: o_mask = MASK_Z;
      default:                        o_mask = MASK_NONE;
    endcase
  end

endmodule

// File: rtl/flag_unit.sv
// flag_unit: architectural Z/V/N flag register plus the one-cycle branch
// hazard generator for flag-reading branches in ID.
//   clk, rst : clock, synchronous active-high reset
//   bus      : flag_unit_if slave (EX result/opcode, pipeline control,
//              ID branch info in; flags, flag_hazard, flags_busy out)
// DW must match the DW of the connected interface.
//
// state   | meaning
// HZ_IDLE | no flag write awaiting a dependent branch
// HZ_WAIT | flags just updated; the stalled branch evaluates now
module flag_unit
  import cpu_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic       clk,
  input  logic       rst,
  flag_unit_if.slave bus
);

  logic [2:0] w_mask;
  logic [2:0] w_new;
  logic       w_we;
  logic       w_hazard;
  logic [2:0] r_flags;
  logic       r_busy;
  hz_state_t  r_state;

  flag_mask_dec u_mask_dec (
    .i_op   (bus.ex_op),
    .o_mask (w_mask)
  );

  always_comb begin
    w_new         = 3'b000;
    w_new[FLAG_Z] = (bus.ex_result == '0);
    w_new[FLAG_V] = bus.ex_ovfl;
    w_new[FLAG_N] = bus.ex_result[DW-1];
  end

  assign w_we = bus.ex_valid & ~bus.stall & ~bus.flush & (|w_mask);

  // Conservative: any non-unconditional branch stalls behind any flag write,
  // regardless of which flags the condition actually reads. Identical in
  // IDLE and WAIT, so back-to-back writers re-stall a following branch.
  assign w_hazard = ~rst & w_we & bus.id_is_branch & (bus.id_cond != COND_UNCOND);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= 3'b000;
      r_state <= HZ_IDLE;
      r_busy  <= 1'b0;
    end else begin
      if (w_we) begin
        r_flags <= (r_flags & ~w_mask) | (w_new & w_mask);
      end
      case (r_state)
        HZ_IDLE: begin
          if (w_hazard) begin
            r_state <= HZ_WAIT;
            r_busy  <= 1'b1;
          end
        end
        HZ_WAIT: begin
          // A frozen pipeline keeps the branch in ID, so WAIT is held.
          if (w_hazard || bus.stall) begin
            r_state <= HZ_WAIT;
            r_busy  <= 1'b1;
          end else begin
            r_state <= HZ_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= HZ_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.flags       = r_flags;
  assign bus.flag_hazard = w_hazard;
  assign bus.flags_busy  = r_busy;

endmodule

// File: tb/tb_flag_unit.sv
// Testbench for flag_unit: directed vector table followed by random
// stimulus compared against a behavioural model of the flag rules.
module tb_flag_unit;

  logic clk = 1'b0;
  logic rst;

  flag_unit_if #(.DW(16)) bus ();

  flag_unit #(.DW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [3:0]  op;
    logic [15:0] res;
    logic        ovfl;
    logic        stall;
    logic        flush;
    logic        br;
    logic [2:0]  cond;
    logic        exp_hz;
    logic [2:0]  exp_flags;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(logic r, logic v, logic [3:0] op, logic [15:0] res,
                              logic ov, logic st, logic fl, logic br, logic [2:0] cond,
                              logic hz, logic [2:0] fg, logic bz);
    vec_t x;
    x.rst = r; x.valid = v; x.op = op; x.res = res; x.ovfl = ov;
    x.stall = st; x.flush = fl; x.br = br; x.cond = cond;
    x.exp_hz = hz; x.exp_flags = fg; x.exp_busy = bz;
    return x;
  endfunction

  task automatic chk(input string name, input int idx, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step=%0d got=%b expected=%b", name, idx, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [3:0] op, input logic [15:0] res,
                       input logic ov, input logic st, input logic fl, input logic br,
                       input logic [2:0] cond);
    rst              = r;
    bus.ex_valid     = v;
    bus.ex_op        = op;
    bus.ex_result    = res;
    bus.ex_ovfl      = ov;
    bus.stall        = st;
    bus.flush        = fl;
    bus.id_is_branch = br;
    bus.id_cond      = cond;
  endtask

  // Behavioural model state
  logic m_z, m_v, m_n, m_waiting;

  initial begin
    drive(1, 0, 4'd0, 16'h0, 0, 0, 0, 0, 3'd0);

    //          rst v  op     result    ov st fl br cond  hz flags   busy
    vecs.push_back(mk(1, 0, 4'h0, 16'h0000, 0, 0, 0, 0, 3'd0, 0, 3'b000, 0));
    vecs.push_back(mk(0, 1, 4'h0, 16'h0000, 0, 0, 0, 0, 3'd0, 0, 3'b100, 0));
    vecs.push_back(mk(0, 1, 4'h0, 16'h8000, 1, 0, 0, 0, 3'd0, 0, 3'b011, 0));
    vecs.push_back(mk(0, 1, 4'h2, 16'h0000, 0, 0, 0, 0, 3'd0, 0, 3'b111, 0));
    vecs.push_back(mk(0, 1, 4'h2, 16'h8001, 0, 0, 0, 0, 3'd0, 0, 3'b011, 0));
    vecs.push_back(mk(0, 1, 4'h0, 16'h0000, 0, 0, 0, 0, 3'd0, 0, 3'b100, 0));
    vecs.push_back(mk(0, 1, 4'h1, 16'hFFFE, 1, 0, 0, 1, 3'd0, 1, 3'b011, 1));
    vecs.push_back(mk(0, 0, 4'h0, 16'h0000, 0, 0, 0, 1, 3'd0, 0, 3'b011, 0));
    vecs.push_back(mk(0, 1, 4'h0, 16'h0000, 0, 0, 0, 1, 3'd7, 0, 3'b100, 0));
    vecs.push_back(mk(0, 1, 4'h0, 16'h8000, 1, 0, 1, 1, 3'd1, 0, 3'b100, 0));
    vecs.push_back(mk(0, 1, 4'h2, 16'h0005, 0, 0, 0, 1, 3'd6, 1, 3'b000, 1));
    vecs.push_back(mk(0, 1, 4'h1, 16'h0000, 0, 1, 0, 1, 3'd0, 0, 3'b000, 1));
    vecs.push_back(mk(0, 0, 4'h0, 16'h0000, 0, 1, 0, 0, 3'd0, 0, 3'b000, 1));
    vecs.push_back(mk(0, 0, 4'h0, 16'h0000, 0, 1, 0, 0, 3'd0, 0, 3'b000, 1));
    vecs.push_back(mk(0, 0, 4'h0, 16'h0000, 0, 0, 0, 0, 3'd0, 0, 3'b000, 0));
    vecs.push_back(mk(0, 1, 4'h1, 16'h0000, 0, 1, 0, 1, 3'd0, 0, 3'b000, 0));
    vecs.push_back(mk(0, 1, 4'h0, 16'h0000, 0, 0, 0, 1, 3'd0, 1, 3'b100, 1));
    vecs.push_back(mk(0, 1, 4'h1, 16'h8000, 0, 0, 0, 1, 3'd3, 1, 3'b001, 1));
    vecs.push_back(mk(0, 0, 4'h0, 16'h0000, 0, 0, 0, 0, 3'd0, 0, 3'b001, 0));
    vecs.push_back(mk(0, 1, 4'h0, 16'hFFFF, 0, 0, 0, 1, 3'd0, 1, 3'b001, 1));
    vecs.push_back(mk(0, 1, 4'h0, 16'h0000, 0, 0, 1, 1, 3'd0, 0, 3'b001, 0));
    vecs.push_back(mk(1, 1, 4'h0, 16'h0000, 0, 0, 0, 1, 3'd0, 0, 3'b000, 0));
    vecs.push_back(mk(0, 1, 4'h0, 16'h0000, 0, 0, 0, 1, 3'd0, 1, 3'b100, 1));
    vecs.push_back(mk(1, 0, 4'h0, 16'h0000, 0, 0, 0, 0, 3'd0, 0, 3'b000, 0));
    vecs.push_back(mk(0, 1, 4'h8, 16'h0000, 0, 0, 0, 0, 3'd0, 0, 3'b000, 0));
    vecs.push_back(mk(0, 1, 4'h0, 16'h8000, 1, 0, 0, 0, 3'd0, 0, 3'b011, 0));
    vecs.push_back(mk(0, 1, 4'h7, 16'h0000, 0, 0, 0, 0, 3'd0, 0, 3'b011, 0));
    vecs.push_back(mk(0, 0, 4'h0, 16'h0000, 0, 0, 0, 0, 3'd0, 0, 3'b011, 0));
    vecs.push_back(mk(0, 1, 4'h4, 16'h0000, 0, 0, 0, 0, 3'd0, 0, 3'b111, 0));
    vecs.push_back(mk(0, 1, 4'h5, 16'h0005, 0, 0, 0, 0, 3'd0, 0, 3'b011, 0));
    vecs.push_back(mk(0, 1, 4'h6, 16'h0000, 0, 0, 0, 1, 3'd2, 1, 3'b111, 1));
    vecs.push_back(mk(0, 1, 4'h3, 16'h0000, 0, 0, 0, 1, 3'd0, 0, 3'b111, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].valid, vecs[i].op, vecs[i].res, vecs[i].ovfl,
            vecs[i].stall, vecs[i].flush, vecs[i].br, vecs[i].cond);
      #2;
      chk("hazard", i, {2'b00, bus.flag_hazard}, {2'b00, vecs[i].exp_hz});
      @(posedge clk);
      #1;
      chk("flags", i, bus.flags, vecs[i].exp_flags);
      chk("busy", i, {2'b00, bus.flags_busy}, {2'b00, vecs[i].exp_busy});
    end

    // Random phase against a rule-level model
    m_z = 0; m_v = 0; m_n = 0; m_waiting = 0;
    for (int i = 0; i < 400; i++) begin
      logic        r, v, ov, st, fl, br;
      logic [3:0]  op;
      logic [15:0] res;
      logic [2:0]  cond;
      logic        full_w, z_only_w, we, exp_hz;
      int          sel;

      r    = (i == 0) || ($urandom_range(0, 31) == 0);
      v    = ($urandom_range(0, 3) != 0);
      op   = 4'($urandom_range(0, 15));
      sel  = $urandom_range(0, 3);
      res  = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'h8000 : 16'($urandom);
      ov   = 1'($urandom);
      st   = ($urandom_range(0, 3) == 0);
      fl   = ($urandom_range(0, 4) == 0);
      br   = 1'($urandom);
      cond = 3'($urandom_range(0, 7));

      full_w   = (op == 4'd0) || (op == 4'd1);
      z_only_w = (op == 4'd2) || (op == 4'd4) || (op == 4'd5) || (op == 4'd6);
      we       = v && !st && !fl && (full_w || z_only_w);
      exp_hz   = !r && we && br && (cond != 3'd7);

      drive(r, v, op, res, ov, st, fl, br, cond);
      #2;
      chk("rnd_hazard", i, {2'b00, bus.flag_hazard}, {2'b00, exp_hz});

      if (r) begin
        m_z = 0; m_v = 0; m_n = 0; m_waiting = 0;
      end else begin
        if (we) begin
          m_z = (res == 16'd0);
          if (full_w) begin
            m_v = ov;
            m_n = (res >= 16'h8000);
          end
        end
        m_waiting = exp_hz || (m_waiting && st);
      end

      @(posedge clk);
      #1;
      chk("rnd_flags", i, bus.flags, {m_z, m_v, m_n});
      chk("rnd_busy", i, {2'b00, bus.flags_busy}, {2'b00, m_waiting});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flag_unit.md
# flag_unit

Producer side of the branch-condition interface. Holds the architectural Z/V/N flag register and updates it from EX-stage ALU results using a per-opcode update mask. Presents the flags to the branch-condition evaluator in ID as a 3-bit bus, ordered `flags[2]=Z`, `flags[1]=V`, `flags[0]=N`. Also raises a one-cycle hazard stall whenever a flag-reading branch in ID would otherwise see stale flags.

## Interface
- `DW`, default 16: ALU result width.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ex_valid` in 1: the EX stage holds a real (non-bubble) instruction.
- `ex_op` in 4: EX-stage opcode.
- `ex_result` in DW: ALU result.
- `ex_ovfl` in 1: signed overflow from the ALU add/sub path.
- `stall` in 1: pipeline freeze; EX does not advance.
- `flush` in 1: kill the EX-stage instruction.
- `id_is_branch` in 1: the ID stage holds B or BR.
- `id_cond` in 3: the branch condition field.
- `flags` out 3: registered {Z,V,N} for branch evaluation.
- `flag_hazard` out 1: stall request to the hazard unit.
- `flags_busy` out 1: a flag write is in flight (debug/visibility).

## Operation
- Flag derivation from EX:
  - `Z = (ex_result == 0)` over the full DW bits.
  - `N = ex_result[DW-1]`.
  - `V = ex_ovfl`.
- Update mask by `ex_op`:
  - ADD (0000), SUB (0001): write Z, V, N.
  - XOR (0010), SLL (0100), SRA (0101), ROR (0110): write Z only.
  - All other opcodes: no write.
  - Unwritten bits hold their value.
- Write enable is `ex_valid & ~stall & ~flush & (mask != 0)`. The write lands on the next rising edge.
- Hazard state machine, two states:
  - IDLE: if a flag write is enabled this cycle AND `id_is_branch` AND `id_cond != 3'b111`, go to WAIT and assert `flag_hazard` combinationally in this same cycle.
  - WAIT: `flags` now holds the new value. Deassert `flag_hazard` and return to IDLE.
  - Unconditional branches (cond 111) never raise a hazard.
  - OVFL (cond 110) raises a hazard even when the mask is Z-only. The rule is conservative and does not inspect which bits the branch reads.
- `flags_busy` is high in WAIT.
- `flush` in IDLE: no write and no hazard.
- `flush` in WAIT: the state still returns to IDLE next cycle, because the write has already landed.
- `stall` in IDLE: no write and no hazard.
- `stall` in WAIT: the state holds WAIT until `stall` drops; `flag_hazard` stays low.
- Reset:
  - `flags = 3'b000`, state = IDLE.
  - `flag_hazard = 0`, `flags_busy = 0`.
  - Reset has priority over a simultaneous write or hazard.
  - Reset asserted mid-WAIT returns to IDLE and clears the flags.

## Timing
- Flag write latency is 1 cycle: EX in cycle t gives `flags` valid in cycle t+1.
- There is no combinational path from `ex_result` to `flags`.
- `flag_hazard` is combinational from the ex_*/id_* inputs and the current state. It is high for exactly one cycle per dependent branch, so the branch evaluates in cycle t+1 against the updated flags.
- Back-to-back flag writers (t, t+1) each update `flags` on consecutive edges.
- A branch in ID at t+1 that follows a writer at t+1 stalls again; a new hazard can be raised from WAIT.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants (`OP_ADD`, `OP_SUB`, `OP_XOR`, `OP_SLL`, `OP_SRA`, `OP_ROR`);
  - flag bit indices `FLAG_Z=2`, `FLAG_V=1`, `FLAG_N=0`;
  - condition encodings `COND_NEQ`…`COND_UNCOND`;
  - the 2-state hazard enum.
- One natural sub-module, `flag_mask_dec`: combinational, maps `ex_op` to a 3-bit update mask.
- The register and FSM live in the top level.

## Test plan
1. Reset then ADD with `ex_result=0`, `ex_ovfl=0` → `flags=3'b100` one cycle later; `flag_hazard` stays 0 with no branch in ID.
2. With `flags=3'b111`, XOR with result 16'h8001 → `flags=3'b011`; only Z changes, V and N hold.
3. SUB with result 16'hFFFE and ovfl=1, while ID has a branch with cond 000 → `flag_hazard=1` for 1 cycle; next cycle `flags=3'b011`, hazard 0, `flags_busy=1`.
4. ADD in EX with cond 111 branch in ID → no hazard. Same case with `flush=1` and cond 001 → no hazard and `flags` unchanged.
5. SUB in EX with `stall=1` → no write. Writer then in WAIT with `stall=1` for 3 cycles → state holds WAIT and `flag_hazard=0` throughout.
6. Assert `rst` in the cycle an ADD writes → `flags=000`, IDLE. Then LW (no-mask opcode) with result 0 → `flags` stays 000.
